// File: rtl/pwm_voice_mixer.sv
// pwm_voice_mixer: multi-voice phase-accumulator tone generator with a PWM DAC.
// On each sample tick the voices are walked one per clock, mixed into one
// PWM_W-bit sample, and that sample drives a glitch-free PWM bitstream.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   sample_tick_i          one-cycle request for a new mixed sample
//   cfg_we_i, cfg_addr_i   voice configuration write strobe / voice index
//   cfg_incr_i, cfg_vol_i  phase increment per sample, voice volume
//   cfg_wave_i             0 off, 1 square, 2 saw, 3 triangle
//   cfg_sync_i             with cfg_we_i: clear that voice's accumulator
//   sample_o               last mixed sample
//   sample_valid_o         one-cycle pulse when sample_o updates
//   busy_o                 mixer is walking the voices
//   overrun_o              sticky: a tick arrived while busy
//   pwm_o                  PWM audio bitstream
module pwm_voice_mixer #(
    parameter int unsigned VOICES = 4,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned VOL_W  = 4,
    parameter int unsigned PWM_W  = 8
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          sample_tick_i,
    input  logic                                          cfg_we_i,
    input  logic [((VOICES > 1) ? $clog2(VOICES) : 1)-1:0] cfg_addr_i,
    input  logic [ACC_W-1:0]                              cfg_incr_i,
    input  logic [VOL_W-1:0]                              cfg_vol_i,
    input  logic [1:0]                                    cfg_wave_i,
    input  logic                                          cfg_sync_i,
    output logic [PWM_W-1:0]                              sample_o,
    output logic                                          sample_valid_o,
    output logic                                          busy_o,
    output logic                                          overrun_o,
    output logic                                          pwm_o
);

    localparam int unsigned IDX_W  = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int unsigned SHIFT  = $clog2(VOICES);
    localparam int unsigned SUM_W  = PWM_W + SHIFT;
    localparam int unsigned PROD_W = PWM_W + VOL_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [PWM_W-1:0]   sample_q, sample_d;
    logic               sample_valid_q, sample_valid_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic [PWM_W-1:0]   pwm_cnt_q;
    logic [PWM_W-1:0]   level_q;
    logic               pwm_q;

    logic [ACC_W-1:0]   acc_q  [VOICES];
    logic [ACC_W-1:0]   incr_q [VOICES];
    logic [VOL_W-1:0]   vol_q  [VOICES];
    logic [1:0]         wave_q [VOICES];

    logic [ACC_W-1:0]   acc_new_c;
    logic [PWM_W-1:0]   tri_c;
    logic [PWM_W-1:0]   wave_c;
    logic [PROD_W-1:0]  prod_c;
    logic [PWM_W-1:0]   contrib_c;

    // Waveform of the voice in the current RUN slot, taken from its advanced phase
    assign acc_new_c = acc_q[idx_q] + incr_q[idx_q];
    assign tri_c     = acc_new_c[ACC_W-2 -: PWM_W];

    always_comb begin
        wave_c = '0;
        case (wave_q[idx_q])
            2'd1:    wave_c = {PWM_W{acc_new_c[ACC_W-1]}};
            2'd2:    wave_c = acc_new_c[ACC_W-1 -: PWM_W];
            2'd3:    wave_c = acc_new_c[ACC_W-1] ? ~tri_c : tri_c;
            default: wave_c = '0;
        endcase
    end

    assign prod_c    = PROD_W'(wave_c) * PROD_W'(vol_q[idx_q]);
    assign contrib_c = PWM_W'(prod_c >> VOL_W);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sample_tick_i) state_d = S_RUN;
            S_RUN:   if (idx_q == IDX_W'(VOICES - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        idx_d          = idx_q;
        sum_d          = sum_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        busy_d         = (state_d != S_IDLE);
        overrun_d      = overrun_q;
        case (state_q)
            S_IDLE: begin
                if (sample_tick_i) begin
                    idx_d = '0;
                    sum_d = '0;
                end
            end
            S_RUN: begin
                sum_d = sum_q + SUM_W'(contrib_c);
                idx_d = idx_q + IDX_W'(1);
            end
            S_DONE: begin
                sample_d       = PWM_W'(sum_q >> SHIFT);
                sample_valid_d = 1'b1;
            end
            default: ;
        endcase
        // Ticks are only accepted in IDLE; anything else is dropped and flagged
        if (sample_tick_i && (state_q != S_IDLE)) overrun_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q          <= '0;
            sum_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            idx_q          <= idx_d;
            sum_q          <= sum_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
        end
    end

    // Voice registers; a sync write beats the RUN update of the same voice
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int v = 0; v < int'(VOICES); v++) begin
                acc_q[v]  <= '0;
                incr_q[v] <= '0;
                vol_q[v]  <= '0;
                wave_q[v] <= 2'd0;
            end
        end else begin
            for (int v = 0; v < int'(VOICES); v++) begin
                if (cfg_we_i && (cfg_addr_i == IDX_W'(v))) begin
                    incr_q[v] <= cfg_incr_i;
                    vol_q[v]  <= cfg_vol_i;
                    wave_q[v] <= cfg_wave_i;
                end
                if (cfg_we_i && cfg_sync_i && (cfg_addr_i == IDX_W'(v))) begin
                    acc_q[v] <= '0;
                end else if ((state_q == S_RUN) && (idx_q == IDX_W'(v))) begin
                    acc_q[v] <= acc_new_c;
                end
            end
        end
    end

    // PWM: level only reloads at the period wrap so a period is never cut short
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pwm_cnt_q <= '0;
            level_q   <= '0;
            pwm_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
            if (pwm_cnt_q == {PWM_W{1'b1}}) level_q <= sample_q;
            pwm_q     <= (pwm_cnt_q < level_q);
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = sample_valid_q;
    assign busy_o         = busy_q;
    assign overrun_o      = overrun_q;
    assign pwm_o          = pwm_q;

endmodule

// File: tb/tb_pwm_voice_mixer.sv
module tb_pwm_voice_mixer;

    localparam int unsigned VOICES = 4;
    localparam int unsigned ACC_W  = 16;
    localparam int unsigned VOL_W  = 4;
    localparam int unsigned PWM_W  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sample_tick = 1'b0;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_addr = '0;
    logic [ACC_W-1:0] cfg_incr = '0;
    logic [VOL_W-1:0] cfg_vol = '0;
    logic [1:0]       cfg_wave = '0;
    logic             cfg_sync = 1'b0;
    logic [PWM_W-1:0] sample_o;
    logic             sample_valid_o;
    logic             busy_o;
    logic             overrun_o;
    logic             pwm_o;

    pwm_voice_mixer #(
        .VOICES(VOICES), .ACC_W(ACC_W), .VOL_W(VOL_W), .PWM_W(PWM_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .sample_tick_i(sample_tick),
        .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_incr_i(cfg_incr),
        .cfg_vol_i(cfg_vol), .cfg_wave_i(cfg_wave), .cfg_sync_i(cfg_sync),
        .sample_o(sample_o), .sample_valid_o(sample_valid_o), .busy_o(busy_o),
        .overrun_o(overrun_o), .pwm_o(pwm_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int smp;
        int due;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every sample_valid pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (sample_valid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_sample_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sample", int'(sample_o), e.smp);
                chk("sample_valid_cycle", cyc, e.due);
            end
        end
    end

    task automatic cfg_wr(input int a, input int inc, input int vol, input int wave, input bit sync);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = 2'(a);
        cfg_incr = 16'(inc);
        cfg_vol  = 4'(vol);
        cfg_wave = 2'(wave);
        cfg_sync = sync;
        @(negedge clk);
        cfg_we   = 1'b0;
        cfg_sync = 1'b0;
    endtask

    // Issue a tick, queue its expected sample, leave exactly VOICES+2 cycles of spacing
    task automatic tick(input int exp_smp);
        @(negedge clk);
        sample_tick = 1'b1;
        sb.push_back('{exp_smp, cyc + int'(VOICES) + 2});
        @(negedge clk);
        sample_tick = 1'b0;
        chk("busy_in_run", int'(busy_o), 1);
        repeat (VOICES) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        int hi;
        bit prev;
        bit found;

        // Reset held with random inputs: every output stays 0
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sample_tick = 1'($urandom);
            cfg_we      = 1'($urandom);
            cfg_addr    = 2'($urandom);
            cfg_incr    = 16'($urandom);
            cfg_vol     = 4'($urandom);
            cfg_wave    = 2'($urandom);
            cfg_sync    = 1'($urandom);
            #1;
            chk("rst_sample", int'(sample_o), 0);
            chk("rst_valid", int'(sample_valid_o), 0);
            chk("rst_busy", int'(busy_o), 0);
            chk("rst_overrun", int'(overrun_o), 0);
            chk("rst_pwm", int'(pwm_o), 0);
        end
        @(negedge clk);
        sample_tick = 0; cfg_we = 0; cfg_sync = 0; cfg_addr = 0;
        cfg_incr = 0; cfg_vol = 0; cfg_wave = 0;
        rst = 1'b0;

        // No ticks: pwm stays low
        hi = 0;
        repeat (1000) begin
            @(negedge clk);
            hi += int'(pwm_o);
        end
        chk("idle_pwm_high_count", hi, 0);

        // Square wrap on voice 0: 255*15>>4 = 239, /4 = 59; second tick wraps to 0
        cfg_wr(0, 16'h8000, 15, 1, 1'b1);
        tick(59);
        tick(0);

        // Four square voices in phase: 4*239 >> 2 = 239
        for (int v = 0; v < 4; v++) cfg_wr(v, 16'h8000, 15, 1, 1'b1);
        tick(239);

        // Saw on voice 0: phases 0x1000,0x2000,0x3000 -> 16,32,48 -> 15,30,45 -> 3,7,11
        cfg_wr(0, 16'h1000, 15, 2, 1'b1);
        for (int v = 1; v < 4; v++) cfg_wr(v, 0, 0, 0, 1'b1);
        tick(3);
        tick(7);
        tick(11);

        // Triangle: phase 0x8000 -> t=0x00 inverted to 0xFF -> 239 -> 59
        cfg_wr(0, 16'h8000, 15, 3, 1'b1);
        tick(59);

        // Sync during voice 0's slot: square incr 0x4000
        cfg_wr(0, 16'h4000, 15, 1, 1'b1);
        tick(0);                                  // acc 0x4000
        @(negedge clk);
        sample_tick = 1'b1;
        sb.push_back('{59, cyc + int'(VOICES) + 2}); // slot sees 0x8000
        @(negedge clk);
        sample_tick = 1'b0;
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_incr = 16'h4000;
        cfg_vol = 4'd15; cfg_wave = 2'd1; cfg_sync = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; cfg_sync = 1'b0;
        chk("acc0_after_sync", int'(dut.acc_q[0]), 0);
        repeat (VOICES - 1) @(negedge clk);
        tick(0);                                  // from 0: 0x4000 -> 0 (else 0xC000 -> 59)

        // Overrun: second tick two cycles later is dropped
        chk("overrun_before", int'(overrun_o), 0);
        @(negedge clk);
        sample_tick = 1'b1;
        sb.push_back('{59, cyc + int'(VOICES) + 2}); // acc 0x8000
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        #1;
        chk("overrun_set", int'(overrun_o), 1);
        drain();
        repeat (20) @(negedge clk);
        chk("overrun_sticky", int'(overrun_o), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("overrun_cleared_by_rst", int'(overrun_o), 0);

        // PWM duty: v0 square 239 + v1 saw 0x14*15>>4 = 18 -> 257 >> 2 = 64
        cfg_wr(0, 16'h8000, 15, 1, 1'b1);
        cfg_wr(1, 16'h1400, 15, 2, 1'b1);
        tick(64);
        drain();
        prev = pwm_o;
        found = 1'b0;
        for (int i = 0; i < 700 && !found; i++) begin
            @(negedge clk);
            if (pwm_o && !prev) found = 1'b1;
            prev = pwm_o;
        end
        chk("pwm_rise_found", int'(found), 1);
        // One full period at level 64; a new sample (v0 0->0, v1 0x2800 -> 37 -> 9) lands mid-period
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            hi += int'(pwm_o);
            if (i == 100) begin
                sample_tick = 1'b1;
                sb.push_back('{9, cyc + int'(VOICES) + 2});
            end
            if (i == 101) sample_tick = 1'b0;
            @(negedge clk);
        end
        chk("pwm_duty_64", hi, 64);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            hi += int'(pwm_o);
            @(negedge clk);
        end
        chk("pwm_duty_next_period", hi, 9);
        drain();

        // Async reset mid-RUN
        cfg_wr(1, 0, 0, 0, 1'b1);
        cfg_wr(0, 16'h4000, 15, 1, 1'b1);
        tick(0);                                  // acc 0x4000
        tick(59);                                 // acc 0x8000
        drain();
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        chk("busy_before_abort", int'(busy_o), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_sample", int'(sample_o), 0);
        chk("abort_valid", int'(sample_valid_o), 0);
        chk("abort_acc0", int'(dut.acc_q[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
